// File: rtl/sample02_rcs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample02_rcs_pkg
// Description : Shared types and constants for the sample02_rcs scheduled
//               logic evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package sample02_rcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_NOT = 2'd2
  } op_kind_t;

  localparam logic [2:0] NUM_STEPS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/sample02_rcs_fu.sv
`default_nettype none
// ============================================================================
// Module      : rcs_fu
// Description : 3-input functional unit; op selects OR, AND or NOT (NOT uses
//               operand bit 0 only).
// Revision    : 1.0 - initial release
// ============================================================================
module rcs_fu
  import sample02_rcs_pkg::*;
(
  input  op_kind_t   op,
  input  logic [2:0] operands,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_OR:   y = |operands;
      OP_AND:  y = &operands;
      OP_NOT:  y = ~operands[0];
      default: y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sample02_rcs.sv
`default_nettype none
// ============================================================================
// Module      : sample02_rcs
// Description : Evaluates o = !(d&e&k), p = !k over a fixed 7-step schedule
//               sharing one OR, one AND and one NOT unit.
// Revision    : 1.0 - initial release
// ============================================================================
module sample02_rcs
  import sample02_rcs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic       o,
  output logic       p,
  output logic [2:0] step
);

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_step;
  logic [2:0] w_step_nx;
  logic       w_accept;

  logic r_a, r_b, r_c, r_d, r_e;
  logic r_f, r_g, r_h, r_i, r_j, r_k, r_l;
  logic r_o, r_p;

  logic [2:0] w_or_in, w_and_in, w_not_in;
  logic       w_or_y, w_and_y, w_not_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
          w_step_nx  = 3'd1;
        end
      end
      RUN: begin
        if (r_step == NUM_STEPS) begin
          w_state_nx = DONE;
          w_step_nx  = 3'd0;
        end else begin
          w_step_nx  = r_step + 3'd1;
        end
      end
      DONE: begin
        if (start) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
          w_step_nx  = 3'd1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_step_nx  = 3'd0;
      end
    endcase
  end

  // Idle operand values are the identity of each unit so inactive units output 0/1 harmlessly.
  always_comb begin
    w_or_in  = 3'b000;
    w_and_in = 3'b111;
    w_not_in = 3'b001;
    if (r_state == RUN) begin
      case (r_step)
        3'd1: begin
          w_or_in  = {1'b0, r_a, r_b};
          w_and_in = {1'b1, r_b, r_d};
        end
        3'd2: w_or_in  = {1'b0, r_f, r_g};
        3'd3: w_or_in  = {1'b0, r_c, r_h};
        3'd4: w_or_in  = {r_e, r_f, r_g};
        3'd5: w_and_in = {1'b1, r_i, r_j};
        3'd6: begin
          w_and_in = {r_d, r_e, r_k};
          w_not_in = {2'b00, r_k};
        end
        3'd7: w_not_in = {2'b00, r_l};
        default: ;
      endcase
    end
  end

  rcs_fu u_fu_or  (.op(OP_OR),  .operands(w_or_in),  .y(w_or_y));
  rcs_fu u_fu_and (.op(OP_AND), .operands(w_and_in), .y(w_and_y));
  rcs_fu u_fu_not (.op(OP_NOT), .operands(w_not_in), .y(w_not_y));

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_a, r_b, r_c, r_d, r_e}               <= 5'd0;
      {r_f, r_g, r_h, r_i, r_j, r_k, r_l}     <= 7'd0;
      r_o                                     <= 1'b0;
      r_p                                     <= 1'b0;
    end else begin
      if (w_accept) begin
        {r_a, r_b, r_c, r_d, r_e} <= {a, b, c, d, e};
      end
      if (r_state == RUN) begin
        case (r_step)
          3'd1: begin
            r_f <= w_or_y;
            r_g <= w_and_y;
          end
          3'd2: r_h <= w_or_y;
          3'd3: r_i <= w_or_y;
          3'd4: r_j <= w_or_y;
          3'd5: r_k <= w_and_y;
          3'd6: begin
            r_l <= w_and_y;
            r_p <= w_not_y;
          end
          3'd7: r_o <= w_not_y;
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign step = r_step;
  assign o    = r_o;
  assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_sample02_rcs.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample02_rcs
// Description : Scoreboard bench for sample02_rcs: expected results are queued
//               at issue time and checked whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample02_rcs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic       busy, done, o, p;
  logic [2:0] step;

  typedef struct {
    logic exp_o;
    logic exp_p;
    int   due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sample02_rcs dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .o(o), .p(p), .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference equations, used only for the exhaustive sweep.
  function automatic logic [1:0] ref_op(input logic [4:0] v);
    logic ra, rb, rc, rd, re, f, g, k;
    {ra, rb, rc, rd, re} = v;
    f = ra | rb;
    g = rb & rd;
    k = (rc | f | g) & (re | f | g);
    return {~(rd & re & k), ~k};
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("done_cycle", cyc, x.due);
          chk("result_o", o, x.exp_o);
          chk("result_p", p, x.exp_p);
          chk("done_busy", busy, 0);
          chk("done_step", step, 0);
        end
      end
    end
  end

  // One run: start for one cycle, then scramble inputs to show they are not re-sampled.
  task automatic issue(input logic [4:0] v, input logic eo, input logic ep);
    @(negedge clk);
    {a, b, c, d, e} = v;
    start = 1'b1;
    q.push_back('{eo, ep, cyc + 8});
    @(negedge clk);
    start = 1'b0;
    {a, b, c, d, e} = ~v;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_o", o, 0);
    chk("rst_p", p, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);

    // Directed vectors {a,b,c,d,e}
    issue(5'b00000, 1'b1, 1'b1);
    issue(5'b11111, 1'b0, 1'b0);
    issue(5'b10000, 1'b1, 1'b0);
    issue(5'b00000, 1'b1, 1'b1);

    // c=d=e=1: step trace; p flips after step 6, o after step 7
    @(negedge clk);
    {a, b, c, d, e} = 5'b00111;
    start = 1'b1;
    t0 = cyc;
    q.push_back('{1'b0, 1'b0, t0 + 8});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      {a, b, c, d, e} = 5'b11000;
      chk("trace_step", step, (k <= 7) ? k : 0);
      chk("trace_busy", busy, (k <= 7) ? 1 : 0);
      chk("trace_p", p, (k >= 7) ? 0 : 1);
      chk("trace_o", o, (k >= 8) ? 0 : 1);
    end
    repeat (2) @(negedge clk);

    // start held high: runs back to back, inputs changed mid-run are ignored
    @(negedge clk);
    {a, b, c, d, e} = 5'b11111;
    start = 1'b1;
    t0 = cyc;
    q.push_back('{1'b0, 1'b0, t0 + 8});
    q.push_back('{1'b1, 1'b1, t0 + 16});
    q.push_back('{1'b1, 1'b0, t0 + 24});
    @(negedge clk);
    {a, b, c, d, e} = 5'b00000;
    chk("b2b_step1", step, 1);
    repeat (3) @(negedge clk);
    chk("b2b_ignore_step", step, 4);
    repeat (5) @(negedge clk);
    {a, b, c, d, e} = 5'b10000;
    chk("b2b_restart_step", step, 1);
    repeat (8) @(negedge clk);
    start = 1'b0;
    {a, b, c, d, e} = 5'b01011;
    chk("b2b_third_step", step, 1);
    repeat (10) @(negedge clk);

    // reset during step 4 aborts the run with no done pulse
    @(negedge clk);
    {a, b, c, d, e} = 5'b11111;
    start = 1'b1;
    q.push_back('{1'b0, 1'b0, cyc + 8});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_at_step4", step, 4);
    rst = 1'b1;
    start = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_step", step, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_o", o, 0);
    chk("abort_p", p, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    issue(5'b00111, 1'b0, 1'b0);

    // exhaustive sweep against the reference equations
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      logic [1:0] r;
      v = i[4:0];
      r = ref_op(v);
      issue(v, r[1], r[0]);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
